// File: rtl/qbus_pkg.sv
// Shared types and constants for the QBUS DMA bus-mastership arbiter.
package qbus_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StAck,
      StGrant,
      StRel
   } arb_state_e;

   // QBUS control lines are active low
   localparam logic QbusAsserted = 1'b0;
   localparam logic QbusNegated  = 1'b1;

   localparam int unsigned WdWidth = 10;

endpackage

// File: rtl/qbus_dma_arb_if.sv
// DMA request/grant and QBUS handshake bundle between the arbiter and its bus peers.
interface qbus_dma_arb_if #(
   parameter int unsigned NREQ = 4
) ();

   logic [NREQ-1:0] dma_req;
   logic [NREQ-1:0] dma_gnt;
   logic            dma_tmo;
   logic            pin_dmr_n;
   logic            pin_sack_n;
   logic            pin_dmgo_n;
   logic            pin_sync_n;
   logic            pin_din_n;
   logic            pin_dout_n;
   logic            pin_rply_n;

   modport master (
      input  dma_req,
      input  pin_dmgo_n,
      input  pin_sync_n,
      input  pin_din_n,
      input  pin_dout_n,
      input  pin_rply_n,
      output dma_gnt,
      output dma_tmo,
      output pin_dmr_n,
      output pin_sack_n
   );

   modport slave (
      output dma_req,
      output pin_dmgo_n,
      output pin_sync_n,
      output pin_din_n,
      output pin_dout_n,
      output pin_rply_n,
      input  dma_gnt,
      input  dma_tmo,
      input  pin_dmr_n,
      input  pin_sack_n
   );

endinterface

// File: rtl/qbus_prio_enc.sv
// Combinational winner picker: fixed priority (index 0 highest) or round-robin from ptr.
module qbus_prio_enc #(
   parameter int unsigned NREQ   = 4,
   parameter bit          ARB_RR = 1'b0,
   parameter int unsigned PtrW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PtrW-1:0] ptr,
   output logic [NREQ-1:0] win
);

   always_comb begin
      int unsigned idx;
      logic        found;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // round-robin walks upward from ptr and wraps; fixed priority walks from 0
         idx = ARB_RR ? ((32'(ptr) + k) % NREQ) : k;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/qbus_dma_arb.sv
// QBUS bus-mastership arbiter: DMR/DMGO/SACK handshake toward the CPU, one-hot DMA grant,
// and a no-reply watchdog on the owner's DIN/DOUT strobes.
module qbus_dma_arb
   import qbus_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned TOUT   = 64,
   parameter bit          ARB_RR = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   qbus_dma_arb_if.master bus
);

   localparam int unsigned        PtrW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TOUT - 1);

   arb_state_e         state_q;
   logic [NREQ-1:0]    win;
   logic [NREQ-1:0]    win_q;
   logic [NREQ-1:0]    gnt_q;
   logic [PtrW-1:0]    ptr_q;
   logic [PtrW-1:0]    ptr_next;
   logic [WdWidth-1:0] wd_q;
   logic [WdWidth-1:0] wd_d;
   logic               dmr_n_q;
   logic               sack_n_q;
   logic               tmo_q;
   logic               any_req;
   logic               owner_req;
   logic               cpu_idle;
   logic               strobe;

   qbus_prio_enc #(
      .NREQ  (NREQ),
      .ARB_RR(ARB_RR),
      .PtrW  (PtrW)
   ) u_prio_enc (
      .req(bus.dma_req),
      .ptr(ptr_q),
      .win(win)
   );

   always_comb begin
      any_req   = |bus.dma_req;
      owner_req = |(bus.dma_req & win_q);
      cpu_idle  = (bus.pin_sync_n == QbusNegated) && (bus.pin_rply_n == QbusNegated);
      strobe    = (bus.pin_din_n == QbusAsserted) || (bus.pin_dout_n == QbusAsserted);
   end

   // Round-robin restarts one slot past the latched winner
   always_comb begin
      ptr_next = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_q[i]) ptr_next = (i == NREQ - 1) ? '0 : PtrW'(i + 1);
      end
   end

   always_comb begin
      wd_d = '0;
      if ((state_q == StGrant) && strobe && (bus.pin_rply_n == QbusNegated)) begin
         wd_d = (wd_q == WdLimit) ? wd_q : wd_q + WdWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         dmr_n_q  <= QbusNegated;
         sack_n_q <= QbusNegated;
         gnt_q    <= '0;
         win_q    <= '0;
         ptr_q    <= '0;
         wd_q     <= '0;
         tmo_q    <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         // single pulse on the transition into saturation
         tmo_q <= (wd_d == WdLimit) && (wd_q != WdLimit);
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  state_q <= StReq;
                  dmr_n_q <= QbusAsserted;
               end
            end
            StReq: begin
               if (!any_req) begin
                  state_q <= StIdle;
                  dmr_n_q <= QbusNegated;
               end else if (bus.pin_dmgo_n == QbusAsserted) begin
                  state_q  <= StAck;
                  dmr_n_q  <= QbusNegated;
                  sack_n_q <= QbusAsserted;
                  win_q    <= win;
               end
            end
            StAck: begin
               if (!owner_req) begin
                  state_q <= StRel;
               end else if (cpu_idle) begin
                  state_q <= StGrant;
                  gnt_q   <= win_q;
                  ptr_q   <= ptr_next;
               end
            end
            StGrant: begin
               if (!owner_req) begin
                  state_q <= StRel;
                  gnt_q   <= '0;
               end
            end
            StRel: begin
               if (bus.pin_sync_n == QbusNegated) begin
                  state_q  <= StIdle;
                  sack_n_q <= QbusNegated;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.dma_gnt    = gnt_q;
   assign bus.dma_tmo    = tmo_q;
   assign bus.pin_dmr_n  = dmr_n_q;
   assign bus.pin_sack_n = sack_n_q;

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Directed plus randomized bench for qbus_dma_arb: a fixed-priority and a round-robin instance
// share stimulus, with a tenure-level reference model for winner choice and watchdog pulses.
module tb_qbus_dma_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TOUT = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sel = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic            dmgo_n = 1'b1;
   logic            sync_n = 1'b1;
   logic            din_n = 1'b1;
   logic            dout_n = 1'b1;
   logic            rply_n = 1'b1;

   logic [NREQ-1:0] gnt;
   logic            tmo;
   logic            dmr_n;
   logic            sack_n;

   int n_vec = 0;
   int n_err = 0;
   int mptr = 0;

   always #5 clk = ~clk;

   qbus_dma_arb_if #(.NREQ(NREQ)) fp_if ();
   qbus_dma_arb_if #(.NREQ(NREQ)) rr_if ();

   assign fp_if.dma_req    = sel ? '0 : req;
   assign rr_if.dma_req    = sel ? req : '0;
   assign fp_if.pin_dmgo_n = dmgo_n;
   assign rr_if.pin_dmgo_n = dmgo_n;
   assign fp_if.pin_sync_n = sync_n;
   assign rr_if.pin_sync_n = sync_n;
   assign fp_if.pin_din_n  = din_n;
   assign rr_if.pin_din_n  = din_n;
   assign fp_if.pin_dout_n = dout_n;
   assign rr_if.pin_dout_n = dout_n;
   assign fp_if.pin_rply_n = rply_n;
   assign rr_if.pin_rply_n = rply_n;

   assign gnt    = sel ? rr_if.dma_gnt : fp_if.dma_gnt;
   assign tmo    = sel ? rr_if.dma_tmo : fp_if.dma_tmo;
   assign dmr_n  = sel ? rr_if.pin_dmr_n : fp_if.pin_dmr_n;
   assign sack_n = sel ? rr_if.pin_sack_n : fp_if.pin_sack_n;

   qbus_dma_arb #(.NREQ(NREQ), .TOUT(TOUT), .ARB_RR(1'b0)) u_fp (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (fp_if)
   );

   qbus_dma_arb #(.NREQ(NREQ), .TOUT(TOUT), .ARB_RR(1'b1)) u_rr (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (rr_if)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference winner: lowest set bit, or first set bit at/after mptr going upward with wrap
   function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r);
      logic [NREQ-1:0] one;
      one = 1;
      if (!sel) return r & (~r + one);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (mptr + k) % NREQ;
         if (r[idx]) return one << idx;
      end
      return '0;
   endfunction

   task automatic tenure(input logic [NREQ-1:0] r, input logic [NREQ-1:0] extra,
                         input bit busy, input int wd_n, input bit wd_restart,
                         output logic [NREQ-1:0] won);
      int pulses;
      int first;
      int second;
      bit use_dout;
      req = r;
      step();
      chk("dmr_on_req", 32'(dmr_n), 0);
      chk("sack_in_req", 32'(sack_n), 1);
      if (busy) sync_n = 1'b0;
      dmgo_n = 1'b0;
      step();
      dmgo_n = 1'b1;
      chk("sack_on_dmgo", 32'(sack_n), 0);
      chk("dmr_off_dmgo", 32'(dmr_n), 1);
      won = pick(r);
      if (busy) begin
         for (int i = 0; i < 3; i++) begin
            step();
            chk("gnt_wait_sync", 32'(gnt), 0);
         end
         sync_n = 1'b1;
         rply_n = 1'b0;
         step();
         chk("gnt_wait_rply", 32'(gnt), 0);
         rply_n = 1'b1;
      end
      step();
      chk("gnt_winner", 32'(gnt), 32'(won));
      if (sel) begin
         for (int i = 0; i < NREQ; i++) if (won[i]) mptr = (i + 1) % NREQ;
      end
      if (wd_n > 0) begin
         use_dout = 1'($urandom_range(0, 1));
         pulses = 0;
         first = 0;
         second = 0;
         if (use_dout) dout_n = 1'b0;
         else din_n = 1'b0;
         for (int c = 1; c <= wd_n; c++) begin
            step();
            if (tmo === 1'b1) begin
               pulses++;
               if (first == 0) first = c;
            end
         end
         if (wd_restart) begin
            rply_n = 1'b0;
            step();
            if (tmo === 1'b1) pulses++;
            rply_n = 1'b1;
            for (int c = 1; c <= wd_n; c++) begin
               step();
               if (tmo === 1'b1) begin
                  pulses++;
                  if (second == 0) second = c;
               end
            end
         end
         din_n = 1'b1;
         dout_n = 1'b1;
         for (int c = 0; c < 3; c++) begin
            step();
            if (tmo === 1'b1) pulses++;
         end
         chk("tmo_pulses", 32'(pulses),
             (wd_n >= int'(TOUT) - 1) ? (wd_restart ? 2 : 1) : 0);
         if (wd_n >= int'(TOUT) - 1) begin
            chk("tmo_latency", 32'(first), TOUT - 1);
            if (wd_restart) chk("tmo_restart_latency", 32'(second), TOUT - 1);
         end
      end
      if (extra != '0) begin
         req = req | extra;
         step();
         step();
         chk("gnt_no_preempt", 32'(gnt), 32'(won));
      end
      req = req & ~won;
      step();
      chk("gnt_clear_on_drop", 32'(gnt), 0);
      chk("sack_held_rel", 32'(sack_n), 0);
      if (busy) begin
         sync_n = 1'b0;
         step();
         chk("sack_held_sync", 32'(sack_n), 0);
         sync_n = 1'b1;
      end
      step();
      chk("sack_release", 32'(sack_n), 1);
      chk("dmr_idle_gap", 32'(dmr_n), 1);
   endtask

   initial begin
      logic [NREQ-1:0] won;
      logic [NREQ-1:0] rr_seq [5];
      rr_seq[0] = 4'b0001;
      rr_seq[1] = 4'b0010;
      rr_seq[2] = 4'b0100;
      rr_seq[3] = 4'b1000;
      rr_seq[4] = 4'b0001;

      // Reset state of both instances
      step();
      step();
      chk("rst_fp_dmr", 32'(fp_if.pin_dmr_n), 1);
      chk("rst_fp_sack", 32'(fp_if.pin_sack_n), 1);
      chk("rst_fp_gnt", 32'(fp_if.dma_gnt), 0);
      chk("rst_fp_tmo", 32'(fp_if.dma_tmo), 0);
      chk("rst_rr_dmr", 32'(rr_if.pin_dmr_n), 1);
      chk("rst_rr_gnt", 32'(rr_if.dma_gnt), 0);
      rst_n = 1'b1;
      step();

      // Fixed priority: single request, then 1010 with a late req[0]
      tenure(4'b0001, 4'b0000, 1'b0, 0, 1'b0, won);
      tenure(4'b1010, 4'b0001, 1'b0, 0, 1'b0, won);
      chk("fp_1010", 32'(won), 32'b0010);
      tenure(4'b1001, 4'b0000, 1'b0, 0, 1'b0, won);
      chk("fp_1001", 32'(won), 32'b0001);
      req = '0;
      step();

      // Busy bus and watchdog with restart
      tenure(4'b0100, 4'b0000, 1'b1, 0, 1'b0, won);
      tenure(4'b0001, 4'b0000, 1'b0, 10, 1'b1, won);
      tenure(4'b0010, 4'b0000, 1'b0, 5, 1'b0, won);

      // Abort in REQ; late DMGO ignored
      req = 4'b0100;
      step();
      chk("abort_dmr_on", 32'(dmr_n), 0);
      req = '0;
      step();
      chk("abort_dmr_off", 32'(dmr_n), 1);
      dmgo_n = 1'b0;
      step();
      step();
      chk("abort_sack", 32'(sack_n), 1);
      dmgo_n = 1'b1;
      // Drop and DMGO on the same edge: drop wins
      req = 4'b0001;
      step();
      req = '0;
      dmgo_n = 1'b0;
      step();
      dmgo_n = 1'b1;
      chk("tie_sack", 32'(sack_n), 1);
      chk("tie_dmr", 32'(dmr_n), 1);
      step();

      // Asynchronous reset while granted
      req = 4'b0001;
      step();
      dmgo_n = 1'b0;
      step();
      dmgo_n = 1'b1;
      step();
      chk("pre_rst_gnt", 32'(gnt), 32'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", 32'(gnt), 0);
      chk("async_rst_sack", 32'(sack_n), 1);
      chk("async_rst_dmr", 32'(dmr_n), 1);
      req = '0;
      step();
      rst_n = 1'b1;
      mptr = 0;
      step();

      // Randomized fixed-priority tenures
      for (int i = 0; i < 12; i++) begin
         tenure(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                1'($urandom_range(0, 1)), won);
      end
      req = '0;
      step();
      step();

      // Round-robin with all requests held
      sel = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         tenure(4'b1111, 4'b0000, 1'b0, 0, 1'b0, won);
         chk("rr_order", 32'(won), 32'(rr_seq[i]));
      end
      for (int i = 0; i < 12; i++) begin
         tenure(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                1'($urandom_range(0, 1)), won);
      end
      req = '0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
